// File: rtl/inv_remap_pkg.sv
// -----------------------------------------------------------------------------
// inv_remap_pkg
// Shared definitions for the inverse piecewise-linear mapper and its forward
// mapper `remap`.
//   W1        : m1 code width
//   W2        : m2 code width (W1-1)
//   CW        : bisection iteration counter width
//   state_t   : controller states IDLE / SEARCH / CHECK / DONE
//   SEG_*     : forward-map segment table (base value and slope shift)
// -----------------------------------------------------------------------------
package inv_remap_pkg;

    localparam int W1 = 8;
    localparam int W2 = W1 - 1;
    localparam int CW = $clog2(W1) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Forward map: the m1 range is split into 2^SEG_BITS equal segments
    // selected by the top m1 bits. Each segment is base + (offset >> shift).
    // The bases leave holes between segments (m2 codes that no m1 maps to),
    // and shifts >= 1 give flat runs, so both ties and gaps exist.
    localparam int SEG_BITS = 2;
    localparam int NSEG     = 1 << SEG_BITS;
    localparam int SEG_BASE  [NSEG] = '{0, 34, 52, 62};
    localparam int SEG_SHIFT [NSEG] = '{1, 2, 3, 4};

    // Overflow-free midpoint of an inclusive [lo, hi] interval with lo <= hi.
    function automatic logic [W1-1:0] bisect_mid(input logic [W1-1:0] lo,
                                                 input logic [W1-1:0] hi);
        return lo + ((hi - lo) >> 1);
    endfunction

endpackage

// File: rtl/inv_remap_remap.sv
// -----------------------------------------------------------------------------
// remap
// Combinational forward piecewise-linear mapper m1 -> m2. Monotone
// nondecreasing over the whole m1 range.
//   i_x  in  W1  m1 code
//   o_y  out W2  mapped m2 code
// -----------------------------------------------------------------------------
module remap
    import inv_remap_pkg::*;
(
    input  logic [W1-1:0] i_x,
    output logic [W2-1:0] o_y
);

    logic [W1-SEG_BITS-1:0] w_off;
    logic [W2-1:0]          w_seg_y [NSEG];

    assign w_off = i_x[W1-SEG_BITS-1:0];

    // One candidate per segment; the top bits pick the live one.
    genvar gi;
    generate
        for (gi = 0; gi < NSEG; gi++) begin : g_seg
            assign w_seg_y[gi] = W2'(SEG_BASE[gi]) + W2'(w_off >> SEG_SHIFT[gi]);
        end
    endgenerate

    assign o_y = w_seg_y[i_x[W1-1 -: SEG_BITS]];

endmodule

// File: rtl/inv_remap.sv
// -----------------------------------------------------------------------------
// inv_remap
// Inverse of the forward mapper `remap`: for a target m2 code returns the
// smallest m1 code x with remap(x) >= target, using a fixed-length bisection
// (one forward evaluation per cycle), then one CHECK cycle on the result.
//   clk        in   1   system clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   in_valid   in   1   target present
//   in_ready   out  1   block can accept a target (IDLE only)
//   in_m2      in   W2  target m2 code
//   out_valid  out  1   result present
//   out_ready  in   1   consumer accepts result
//   out_m1     out  W1  recovered m1 code
//   out_exact  out  1   remap(out_m1) == target
//   out_sat    out  1   target above remap(all-ones); out_m1 is all-ones
// -----------------------------------------------------------------------------
module inv_remap
    import inv_remap_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W2-1:0] in_m2,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W1-1:0] out_m1,
    output logic          out_exact,
    output logic          out_sat
);

    state_t        r_state;
    state_t        w_state_next;

    logic [W2-1:0] r_target;
    logic [W1-1:0] r_lo;
    logic [W1-1:0] r_hi;
    logic [CW-1:0] r_cnt;
    logic [W1-1:0] r_out_m1;
    logic          r_out_exact;
    logic          r_out_sat;

    logic [W1-1:0] w_mid;
    logic [W1-1:0] w_f_in;
    logic [W2-1:0] w_f_out;
    logic          w_ge;
    logic          w_search_last;

    // ---------------------------------------------------------------------
    // Single forward-mapper instance, shared between bisection and check.
    // ---------------------------------------------------------------------
    assign w_mid  = bisect_mid(r_lo, r_hi);
    assign w_f_in = (r_state == CHECK) ? r_lo : w_mid;

    remap u_remap (
        .i_x (w_f_in),
        .o_y (w_f_out)
    );

    assign w_ge          = (w_f_out >= r_target);
    // Always run W1 iterations, even after convergence, for fixed latency.
    assign w_search_last = (r_cnt == CW'(W1 - 1));

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next state
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)      w_state_next = SEARCH;
            SEARCH:  if (w_search_last) w_state_next = CHECK;
            CHECK:                      w_state_next = DONE;
            DONE:    if (out_ready)     w_state_next = IDLE;
            default:                    w_state_next = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------------
    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
    end

    assign out_m1    = r_out_m1;
    assign out_exact = r_out_exact;
    assign out_sat   = r_out_sat;

    // ---------------------------------------------------------------------
    // Search datapath and registered results
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_target    <= '0;
            r_lo        <= '0;
            r_hi        <= '1;
            r_cnt       <= '0;
            r_out_m1    <= '0;
            r_out_exact <= 1'b0;
            r_out_sat   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_target <= in_m2;
                        r_lo     <= '0;
                        r_hi     <= '1;
                        r_cnt    <= '0;
                    end
                end
                SEARCH: begin
                    // Once the interval collapses, stepping lo past hi would
                    // corrupt the answer, so hold it for the remaining cycles.
                    if (r_lo != r_hi) begin
                        if (w_ge) begin
                            r_hi <= w_mid;
                        end else begin
                            r_lo <= w_mid + W1'(1);
                        end
                    end
                    r_cnt <= r_cnt + CW'(1);
                end
                CHECK: begin
                    // lo only stays below target when it reached all-ones.
                    r_out_m1    <= r_lo;
                    r_out_exact <= (w_f_out == r_target);
                    r_out_sat   <= (w_f_out <  r_target);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inv_remap.sv
module tb_inv_remap;
    import inv_remap_pkg::*;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W2-1:0] in_m2;
    logic          out_valid;
    logic          out_ready;
    logic [W1-1:0] out_m1;
    logic          out_exact;
    logic          out_sat;

    int checks = 0;
    int errors = 0;

    inv_remap dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_m2     (in_m2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_m1    (out_m1),
        .out_exact (out_exact),
        .out_sat   (out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference forward map written from the segment description:
    // four equal m1 segments, each base + offset / 2^(segment+1).
    function automatic int ref_f(input int x);
        if (x < 64)       return x / 2;
        else if (x < 128) return 34 + (x - 64) / 4;
        else if (x < 192) return 52 + (x - 128) / 8;
        else              return 62 + (x - 192) / 16;
    endfunction

    // Reference inverse: linear scan for the smallest x with f(x) >= t.
    function automatic void ref_inv(input int t, output int m1, output int exact,
                                    output int sat);
        m1 = 255; exact = 0; sat = 1;
        for (int j = 0; j < 256; j++) begin
            if (ref_f(j) >= t) begin
                m1 = j; sat = 0; exact = (ref_f(j) == t) ? 1 : 0;
                return;
            end
        end
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction; hold = cycles with out_ready low while in DONE,
    // during which spurious in_valid pulses are driven.
    task automatic txn(input int t, input int hold);
        int em, ee, es;
        logic [W1-1:0] m1_s;
        logic          ex_s, sa_s;
        ref_inv(t, em, ee, es);
        chk("in_ready_before", int'(in_ready), 1);
        in_m2    = W2'(t);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 1; i <= W1 + 1; i++) begin
            if (i == 1)      chk("in_ready_busy", int'(in_ready), 0);
            if (i == W1 + 1) chk("no_early_valid", int'(out_valid), 0);
            tick();
        end
        chk("latency_valid", int'(out_valid), 1);
        chk("out_m1", int'(out_m1), em);
        chk("out_exact", int'(out_exact), ee);
        chk("out_sat", int'(out_sat), es);
        $display("txn target=%0d out_m1=%0d exact=%0d sat=%0d (model %0d/%0d/%0d)",
                 t, out_m1, out_exact, out_sat, em, ee, es);
        m1_s = out_m1; ex_s = out_exact; sa_s = out_sat;
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'(h % 2);
            in_m2    = W2'($urandom_range(0, 127));
            tick();
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_ready", int'(in_ready), 0);
            chk("hold_stable", int'({m1_s, ex_s, sa_s} == {out_m1, out_exact, out_sat}), 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("released_valid", int'(out_valid), 0);
        chk("back_idle", int'(in_ready), 1);
    endtask

    initial begin
        int t;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_m2     = '0;
        out_ready = 1'b0;
        #23;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_m1", int'(out_m1), 0);
        chk("rst_out_exact", int'(out_exact), 0);
        chk("rst_out_sat", int'(out_sat), 0);
        rst_n = 1'b1;
        tick();

        // Directed: zero, saturation, gaps, long hold.
        txn(0, 0);
        txn(ref_f(255) + 1, 0);
        txn(127, 0);
        txn(32, 0);
        txn(50, 0);
        txn(60, 10);

        // Reset during SEARCH cycle 3.
        in_m2    = W2'(40);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_out_valid", int'(out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < W1 + 4; i++) begin
            tick();
            chk("midrst_no_output", int'(out_valid), 0);
        end
        txn(40, 0);

        // Exhaustive sweep over every forward image.
        for (int k = 0; k < 256; k++) txn(ref_f(k), 0);

        // Random targets across the whole m2 range, random hold.
        for (int r = 0; r < 40; r++) begin
            t = int'($urandom_range(0, 127));
            txn(t, int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
